// File: rtl/fetch_unit_pkg.sv
// Shared fetch types: 32-bit word, the instruction/PC packet handed to decode,
// and the default reset vector and instruction stride.
package fetch_unit_pkg;

  typedef logic [31:0] u32_t;

  localparam u32_t        RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int unsigned INSN_BYTES_DEFAULT = 4;

  typedef struct packed {
    u32_t instr;
    u32_t pc;
  } fetch_pkt_t;

  // Redirect targets are word addresses; the low two bits carry no meaning.
  function automatic u32_t word_align(input u32_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect request and the
// valid/ready instruction stream towards decode.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  u32_t imem_addr;
  u32_t imem_data;
  logic redirect_valid;
  u32_t redirect_pc;
  logic out_valid;
  logic out_ready;
  u32_t out_instr;
  u32_t out_pc;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc,
    input  imem_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer for fetch packets: parks the in-flight word when decode
// stalls, because memory data is only present for a single cycle.
module fetch_skid
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  fetch_pkt_t in_pkt,
  output logic       out_valid,
  input  logic       out_ready,
  output fetch_pkt_t out_pkt
);

  logic       skid_valid_q, skid_valid_d;
  fetch_pkt_t skid_pkt_q, skid_pkt_d;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = skid_valid_q | in_valid;
  assign out_pkt   = skid_valid_q ? skid_pkt_q : in_pkt;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_pkt_d   = skid_pkt_q;
    if (flush) begin
      skid_valid_d = 1'b0;
    end else if (skid_valid_q && out_ready) begin
      skid_valid_d = 1'b0;
    end else if (in_valid && !skid_valid_q && !out_ready) begin
      skid_valid_d = 1'b1;
      skid_pkt_d   = in_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_pkt_q   <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_pkt_q   <= skid_pkt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues reads to a 1-cycle synchronous memory,
// pairs returned words with their PC and feeds decode through a skid buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter u32_t        RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned INSN_BYTES = INSN_BYTES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  u32_t       fetch_pc_q, fetch_pc_d;
  u32_t       pend_pc_q, pend_pc_d;
  logic       pend_valid_q, pend_valid_d;
  logic       skid_in_ready;
  logic       skid_out_valid;
  logic       issue_en;
  fetch_pkt_t pend_pkt;
  fetch_pkt_t out_pkt;

  assign pend_pkt = '{instr: bus.imem_data, pc: pend_pc_q};

  // A new read may only go out if the word it would displace has somewhere to go.
  assign issue_en = skid_in_ready && !(pend_valid_q && !bus.out_ready);

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d = word_align(bus.redirect_pc);
    end else if (issue_en) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = fetch_pc_q;
      fetch_pc_d   = fetch_pc_q + u32_t'(INSN_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .in_valid  (pend_valid_q),
    .in_ready  (skid_in_ready),
    .in_pkt    (pend_pkt),
    .out_valid (skid_out_valid),
    .out_ready (bus.out_ready),
    .out_pkt   (out_pkt)
  );

  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = skid_out_valid & ~bus.redirect_valid;
  assign bus.out_instr = out_pkt.instr;
  assign bus.out_pc    = out_pkt.pc;

endmodule
